// File: rtl/fwd_source_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_source_pipe_pkg
// Description : Shared types and constants for the back-end pipeline tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_source_pipe_pkg;

    localparam int NSLOT = 3;
    localparam int XLEN  = 32;

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_BR    = 2'b11;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [4:0]      rd;
        logic            reg_write;
        logic [1:0]      op_type;
        logic [XLEN-1:0] data;
    } slot_t;

    localparam slot_t c_SLOT_RESET = '0;

    // x0 is architecturally hard-wired, so a write to it is never exposed.
    function automatic logic f_slot_we(input slot_t s);
        return s.valid & s.reg_write & (s.rd != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_slot_reg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_slot_reg
// Description : One pipeline slot register with load / hold / bubble control.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_slot_reg
    import fwd_source_pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  logic  i_bubble,
    input  slot_t i_d,
    output slot_t o_q
);

    slot_t r_q;

    // Bubble has priority over load; neither asserted means hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= c_SLOT_RESET;
        end else if (i_bubble) begin
            r_q <= c_SLOT_RESET;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/fwd_source_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fwd_source_pipe
// Description : EXE/MEM/WB tracker producing forwarding buses and the RF write.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_source_pipe #(
    parameter int NSLOT = 3,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  reg_DE_flush,
    input  logic [XLEN-1:0]       PC_ID,
    input  logic [XLEN-1:0]       inst_ID,
    input  logic [4:0]            rdAddr_ID,
    input  logic                  regWrite_ctrl,
    input  logic [1:0]            op_type_ID,
    input  logic [XLEN-1:0]       alu_res_EXE,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_ready,
    output logic [NSLOT*XLEN-1:0] PC_out,
    output logic [NSLOT*XLEN-1:0] inst_out,
    output logic [NSLOT*XLEN-1:0] DATA_out,
    output logic [NSLOT*5-1:0]    rdAddr_out,
    output logic [NSLOT-1:0]      regWrite_out,
    output logic [NSLOT*2-1:0]    op_type_out,
    output logic [NSLOT-1:0]      ltype_out,
    output logic                  mem_stall,
    output logic                  regWrite_WB,
    output logic [4:0]            rdAddr_WB,
    output logic [XLEN-1:0]       rdData_WB
);

    import fwd_source_pipe_pkg::*;

    slot_t            w_q [NSLOT];
    slot_t            w_d [NSLOT];
    logic [NSLOT-1:0] w_load;
    logic [NSLOT-1:0] w_bubble;
    logic             w_issue;
    logic             w_mem_op1;
    logic             w_load1_ready;
    logic             w_mem_stall;
    logic [XLEN-1:0]  w_data1;

    assign w_issue       = issue_valid & ~reg_DE_flush;
    assign w_mem_op1     = (w_q[1].op_type == OP_LOAD) | (w_q[1].op_type == OP_STORE);
    assign w_mem_stall   = w_q[1].valid & w_mem_op1 & ~mem_ready;
    assign w_load1_ready = w_q[1].valid & (w_q[1].op_type == OP_LOAD) & mem_ready;
    assign w_data1       = w_load1_ready ? mem_rdata : w_q[1].data;

    always_comb begin
        w_d[0] = c_SLOT_RESET;
        if (w_issue) begin
            w_d[0].valid     = 1'b1;
            w_d[0].pc        = PC_ID;
            w_d[0].inst      = inst_ID;
            w_d[0].rd        = rdAddr_ID;
            w_d[0].reg_write = regWrite_ctrl;
            w_d[0].op_type   = op_type_ID;
        end

        w_d[1]      = w_q[0];
        w_d[1].data = alu_res_EXE;

        w_d[2]      = w_q[1];
        w_d[2].data = w_data1;

        // While memory holds the back end, EXE/MEM freeze and WB drains to a
        // bubble so the stalled instruction cannot retire twice.
        w_load      = {NSLOT{~w_mem_stall}};
        w_bubble    = '0;
        w_bubble[2] = w_mem_stall;
    end

    generate
        for (genvar k = 0; k < NSLOT; k++) begin : g_slot
            fwd_slot_reg u_slot (
                .clk      (clk),
                .rst      (rst),
                .i_load   (w_load[k]),
                .i_bubble (w_bubble[k]),
                .i_d      (w_d[k]),
                .o_q      (w_q[k])
            );
        end
    endgenerate

    generate
        for (genvar k = 0; k < NSLOT; k++) begin : g_pack
            assign PC_out[XLEN*k +: XLEN]   = w_q[k].pc;
            assign inst_out[XLEN*k +: XLEN] = w_q[k].inst;
            assign rdAddr_out[5*k +: 5]     = w_q[k].rd;
            assign regWrite_out[k]          = f_slot_we(w_q[k]);
            assign op_type_out[2*k +: 2]    = w_q[k].op_type;
        end
    endgenerate

    assign DATA_out[XLEN*0 +: XLEN] = alu_res_EXE;
    assign DATA_out[XLEN*1 +: XLEN] = w_data1;
    assign DATA_out[XLEN*2 +: XLEN] = w_q[2].data;

    assign ltype_out[0] = w_q[0].valid & (w_q[0].op_type == OP_LOAD);
    assign ltype_out[1] = w_q[1].valid & (w_q[1].op_type == OP_LOAD) & ~mem_ready;
    assign ltype_out[2] = 1'b0;

    assign mem_stall   = w_mem_stall;
    assign regWrite_WB = regWrite_out[2];
    assign rdAddr_WB   = w_q[2].rd;
    assign rdData_WB   = w_q[2].data;

endmodule
`default_nettype wire

// File: tb/tb_fwd_source_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_source_pipe
// Description : Directed self-checking bench for fwd_source_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_source_pipe;

    localparam logic [1:0] c_OP_ALU   = 2'b00;
    localparam logic [1:0] c_OP_LOAD  = 2'b01;
    localparam logic [1:0] c_OP_STORE = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, reg_DE_flush, regWrite_ctrl, mem_ready;
    logic [31:0] PC_ID, inst_ID, alu_res_EXE, mem_rdata;
    logic [4:0]  rdAddr_ID;
    logic [1:0]  op_type_ID;
    logic [95:0] PC_out, inst_out, DATA_out;
    logic [14:0] rdAddr_out;
    logic [2:0]  regWrite_out, ltype_out;
    logic [5:0]  op_type_out;
    logic        mem_stall, regWrite_WB;
    logic [4:0]  rdAddr_WB;
    logic [31:0] rdData_WB;

    int checks = 0;
    int errors = 0;

    fwd_source_pipe #(.NSLOT(3), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .reg_DE_flush(reg_DE_flush),
        .PC_ID(PC_ID), .inst_ID(inst_ID), .rdAddr_ID(rdAddr_ID),
        .regWrite_ctrl(regWrite_ctrl), .op_type_ID(op_type_ID),
        .alu_res_EXE(alu_res_EXE), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .PC_out(PC_out), .inst_out(inst_out), .DATA_out(DATA_out),
        .rdAddr_out(rdAddr_out), .regWrite_out(regWrite_out), .op_type_out(op_type_out),
        .ltype_out(ltype_out), .mem_stall(mem_stall), .regWrite_WB(regWrite_WB),
        .rdAddr_WB(rdAddr_WB), .rdData_WB(rdData_WB)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_issue(input logic [31:0] pc, input logic [31:0] inst,
                               input logic [4:0] rd, input logic rw, input logic [1:0] op);
        issue_valid   = 1'b1;
        PC_ID         = pc;
        inst_ID       = inst;
        rdAddr_ID     = rd;
        regWrite_ctrl = rw;
        op_type_ID    = op;
    endtask

    task automatic clear_issue();
        issue_valid   = 1'b0;
        PC_ID         = '0;
        inst_ID       = '0;
        rdAddr_ID     = '0;
        regWrite_ctrl = 1'b0;
        op_type_ID    = '0;
    endtask

    task automatic drain();
        clear_issue();
        reg_DE_flush = 1'b0;
        mem_ready    = 1'b1;
        alu_res_EXE  = '0;
        mem_rdata    = '0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_issue();
        reg_DE_flush = 1'b0;
        mem_ready    = 1'b1;
        alu_res_EXE  = '0;
        mem_rdata    = '0;
        #12;
        checks++; if (PC_out !== 96'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", PC_out); end
        checks++; if (inst_out !== 96'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst_out); end
        checks++; if (DATA_out !== 96'h0) begin errors++; $display("FAIL rst_data got %h exp 0", DATA_out); end
        checks++; if ({rdAddr_out, regWrite_out, op_type_out, ltype_out} !== 27'h0) begin
            errors++; $display("FAIL rst_ctrl got %h exp 0", {rdAddr_out, regWrite_out, op_type_out, ltype_out}); end
        checks++; if ({mem_stall, regWrite_WB, rdAddr_WB, rdData_WB} !== 39'h0) begin
            errors++; $display("FAIL rst_wb got %h exp 0", {mem_stall, regWrite_WB, rdAddr_WB, rdData_WB}); end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_alu_chain();
        drain();
        drive_issue(32'h100, 32'h02A00293, 5'd5, 1'b1, c_OP_ALU);
        step();
        clear_issue();
        alu_res_EXE = 32'h2A;
        #1;
        checks++; if (rdAddr_out[4:0] !== 5'd5) begin errors++; $display("FAIL alu_s0_rd got %0d exp 5", rdAddr_out[4:0]); end
        checks++; if (DATA_out[31:0] !== 32'h2A) begin errors++; $display("FAIL alu_s0_data got %h exp 2a", DATA_out[31:0]); end
        checks++; if (PC_out[31:0] !== 32'h100) begin errors++; $display("FAIL alu_s0_pc got %h exp 100", PC_out[31:0]); end
        checks++; if (regWrite_out !== 3'b001) begin errors++; $display("FAIL alu_s0_rw got %b exp 001", regWrite_out); end
        step();
        alu_res_EXE = 32'h0;
        #1;
        checks++; if (rdAddr_out[9:5] !== 5'd5) begin errors++; $display("FAIL alu_s1_rd got %0d exp 5", rdAddr_out[9:5]); end
        checks++; if (DATA_out[63:32] !== 32'h2A) begin errors++; $display("FAIL alu_s1_data got %h exp 2a", DATA_out[63:32]); end
        checks++; if (regWrite_out !== 3'b010) begin errors++; $display("FAIL alu_s1_rw got %b exp 010", regWrite_out); end
        step();
        #1;
        checks++; if (regWrite_WB !== 1'b1) begin errors++; $display("FAIL alu_wb_we got %b exp 1", regWrite_WB); end
        checks++; if (rdData_WB !== 32'h2A) begin errors++; $display("FAIL alu_wb_data got %h exp 2a", rdData_WB); end
        checks++; if (rdAddr_WB !== 5'd5) begin errors++; $display("FAIL alu_wb_rd got %0d exp 5", rdAddr_WB); end
        checks++; if (DATA_out[95:64] !== 32'h2A) begin errors++; $display("FAIL alu_s2_data got %h exp 2a", DATA_out[95:64]); end
        step();
        #1;
        checks++; if (regWrite_WB !== 1'b0) begin errors++; $display("FAIL alu_wb_once got %b exp 0", regWrite_WB); end
    endtask

    task automatic test_load_wait();
        int pulses = 0;
        drain();
        drive_issue(32'h104, 32'h40002383, 5'd7, 1'b1, c_OP_LOAD);
        step();
        clear_issue();
        alu_res_EXE = 32'h400;
        #1;
        checks++; if (ltype_out !== 3'b001) begin errors++; $display("FAIL ld_s0_ltype got %b exp 001", ltype_out); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL ld_s0_stall got %b exp 0", mem_stall); end
        mem_ready = 1'b0;
        step();
        alu_res_EXE = 32'h0;
        #1;
        pulses += int'(regWrite_WB);
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL ld_wait1_stall got %b exp 1", mem_stall); end
        checks++; if (ltype_out !== 3'b010) begin errors++; $display("FAIL ld_wait1_ltype got %b exp 010", ltype_out); end
        checks++; if (DATA_out[63:32] !== 32'h400) begin errors++; $display("FAIL ld_wait1_data got %h exp 400", DATA_out[63:32]); end
        step();
        #1;
        pulses += int'(regWrite_WB);
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL ld_wait2_stall got %b exp 1", mem_stall); end
        checks++; if (ltype_out !== 3'b010) begin errors++; $display("FAIL ld_wait2_ltype got %b exp 010", ltype_out); end
        checks++; if ({rdAddr_out[14:10], regWrite_WB} !== 6'h0) begin
            errors++; $display("FAIL ld_wait2_s2_bubble got %h exp 0", {rdAddr_out[14:10], regWrite_WB}); end
        checks++; if (PC_out[63:32] !== 32'h104) begin errors++; $display("FAIL ld_wait2_hold got %h exp 104", PC_out[63:32]); end
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL ld_ready_stall got %b exp 0", mem_stall); end
        checks++; if (DATA_out[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_ready_data got %h exp deadbeef", DATA_out[63:32]); end
        checks++; if (ltype_out !== 3'b000) begin errors++; $display("FAIL ld_ready_ltype got %b exp 000", ltype_out); end
        step();
        mem_rdata = 32'h0;
        #1;
        pulses += int'(regWrite_WB);
        checks++; if ({regWrite_WB, rdAddr_WB} !== 6'h27) begin
            errors++; $display("FAIL ld_wb_rd got %h exp 27", {regWrite_WB, rdAddr_WB}); end
        checks++; if (rdData_WB !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_wb_data got %h exp deadbeef", rdData_WB); end
        step();
        #1;
        pulses += int'(regWrite_WB);
        checks++; if (pulses != 1) begin errors++; $display("FAIL ld_wb_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_x0();
        drain();
        drive_issue(32'h108, 32'h05500033, 5'd0, 1'b1, c_OP_ALU);
        step();
        clear_issue();
        alu_res_EXE = 32'h55;
        #1;
        checks++; if (regWrite_out !== 3'b000) begin errors++; $display("FAIL x0_s0_rw got %b exp 000", regWrite_out); end
        for (int i = 0; i < 3; i++) begin
            step();
            alu_res_EXE = 32'h0;
            #1;
            checks++; if ({regWrite_out, regWrite_WB} !== 4'h0) begin
                errors++; $display("FAIL x0_rw_%0d got %b exp 0000", i, {regWrite_out, regWrite_WB}); end
            if (i == 0) begin
                checks++; if (DATA_out[63:32] !== 32'h55) begin errors++; $display("FAIL x0_s1_data got %h exp 55", DATA_out[63:32]); end
            end
        end
    endtask

    task automatic test_flush();
        drain();
        drive_issue(32'h200, 32'h01100193, 5'd3, 1'b1, c_OP_ALU);
        step();
        alu_res_EXE = 32'h11;
        drive_issue(32'h204, 32'h00400213, 5'd4, 1'b1, c_OP_ALU);
        reg_DE_flush = 1'b1;
        #1;
        checks++; if (PC_out[31:0] !== 32'h200) begin errors++; $display("FAIL fl_s0_pc got %h exp 200", PC_out[31:0]); end
        step();
        clear_issue();
        reg_DE_flush = 1'b0;
        alu_res_EXE  = 32'h0;
        #1;
        checks++; if ({PC_out[31:0], inst_out[31:0], rdAddr_out[4:0], op_type_out[1:0], regWrite_out[0]} !== 72'h0) begin
            errors++; $display("FAIL fl_bubble got %h exp 0",
                {PC_out[31:0], inst_out[31:0], rdAddr_out[4:0], op_type_out[1:0], regWrite_out[0]}); end
        checks++; if (PC_out[63:32] !== 32'h200) begin errors++; $display("FAIL fl_s1_pc got %h exp 200", PC_out[63:32]); end
        step();
        #1;
        checks++; if ({regWrite_WB, rdAddr_WB} !== 6'h23) begin errors++; $display("FAIL fl_wb_rd got %h exp 23", {regWrite_WB, rdAddr_WB}); end
        checks++; if (rdData_WB !== 32'h11) begin errors++; $display("FAIL fl_wb_data got %h exp 11", rdData_WB); end
    endtask

    task automatic test_stall_flush();
        drain();
        drive_issue(32'h300, 32'h00102023, 5'd0, 1'b0, c_OP_STORE);
        step();
        alu_res_EXE = 32'h80;
        drive_issue(32'h304, 32'h09900493, 5'd9, 1'b1, c_OP_ALU);
        mem_ready = 1'b0;
        step();
        alu_res_EXE = 32'h99;
        drive_issue(32'h308, 32'h00a00513, 5'd10, 1'b1, c_OP_ALU);
        reg_DE_flush = 1'b1;
        #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL sf_stall got %b exp 1", mem_stall); end
        step();
        #1;
        checks++; if ({PC_out[31:0], rdAddr_out[4:0]} !== {32'h304, 5'd9}) begin
            errors++; $display("FAIL sf_s0_hold got %h exp %h", {PC_out[31:0], rdAddr_out[4:0]}, {32'h304, 5'd9}); end
        checks++; if (PC_out[63:32] !== 32'h300) begin errors++; $display("FAIL sf_s1_hold got %h exp 300", PC_out[63:32]); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL sf_stall2 got %b exp 1", mem_stall); end
        mem_ready = 1'b1;
        clear_issue();
        reg_DE_flush = 1'b0;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL sf_release got %b exp 0", mem_stall); end
        step();
        #1;
        checks++; if ({PC_out[95:64], PC_out[63:32], PC_out[31:0]} !== {32'h300, 32'h304, 32'h0}) begin
            errors++; $display("FAIL sf_advance got %h exp %h", PC_out, {32'h300, 32'h304, 32'h0}); end
        checks++; if (DATA_out[63:32] !== 32'h99) begin errors++; $display("FAIL sf_s1_data got %h exp 99", DATA_out[63:32]); end
    endtask

    task automatic test_reset_midflight();
        drain();
        drive_issue(32'h400, 32'h00100093, 5'd1, 1'b1, c_OP_ALU);
        step();
        alu_res_EXE = 32'h1;
        drive_issue(32'h404, 32'h00200113, 5'd2, 1'b1, c_OP_ALU);
        step();
        alu_res_EXE = 32'h2;
        drive_issue(32'h408, 32'h00300193, 5'd3, 1'b1, c_OP_ALU);
        step();
        clear_issue();
        alu_res_EXE = 32'h3;
        #1;
        checks++; if (regWrite_out !== 3'b111) begin errors++; $display("FAIL rm_inflight got %b exp 111", regWrite_out); end
        rst = 1'b0;
        alu_res_EXE = 32'h0;
        #1;
        checks++; if ({PC_out, inst_out, DATA_out} !== 288'h0) begin errors++; $display("FAIL rm_buses got nonzero exp 0"); end
        checks++; if ({rdAddr_out, regWrite_out, op_type_out, ltype_out, mem_stall} !== 28'h0) begin
            errors++; $display("FAIL rm_ctrl got %h exp 0", {rdAddr_out, regWrite_out, op_type_out, ltype_out, mem_stall}); end
        checks++; if ({regWrite_WB, rdAddr_WB, rdData_WB} !== 38'h0) begin
            errors++; $display("FAIL rm_wb got %h exp 0", {regWrite_WB, rdAddr_WB, rdData_WB}); end
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            checks++; if ({regWrite_out, regWrite_WB} !== 4'h0) begin
                errors++; $display("FAIL rm_post_%0d got %b exp 0000", i, {regWrite_out, regWrite_WB}); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_wait();
        test_x0();
        test_flush();
        test_stall_flush();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
